// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle (single-beat AR/R/AW/W/B) with master and slave views.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/byte_to_axi_lite_master.sv
// Decodes host command byte frames into single AXI-Lite reads/writes and streams status/read data back.
// Optional watchdog: define AXI_TIMEOUT_EN to abort AXI phases stalled for TIMEOUT_CYCLES cycles.
module byte_to_axi_lite_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  axi_lite_if.master m_axi_lite,
  output logic       busy
);

  localparam logic [7:0] OP_READ    = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] ST_BAD_OP  = 8'hFF;
  localparam logic [7:0] ST_TIMEOUT = 8'h80;

  // Byte shifting below assumes 32-bit address and data.
  if (AXI_ADDR_WIDTH != 32 || AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("byte_to_axi_lite_master: only 32-bit AXI and TIMEOUT_CYCLES >= 1 are supported");
  end

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, AXI_WR, AXI_B, AXI_AR, AXI_R, TX_RESP
  } state_t;

  state_t                    state_q, state_nxt;
  logic [1:0]                byte_cnt_q;
  logic                      is_wr_q;
  logic                      aw_done_q, w_done_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [7:0]                status_q;
  logic [2:0]                tx_idx_q, tx_last_q;
  logic [7:0]                tx_byte;
  logic                      rx_fire;
  logic                      tmo_hit;

  assign rx_fire = rx_valid && rx_ready;

  assign m_axi_lite.awaddr = addr_q;
  assign m_axi_lite.araddr = addr_q;
  assign m_axi_lite.awprot = 3'b000;
  assign m_axi_lite.arprot = 3'b000;
  assign m_axi_lite.wdata  = wdata_q;
  assign m_axi_lite.wstrb  = '1;

`ifdef AXI_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            in_axi;

  assign in_axi  = (state_q == AXI_WR) || (state_q == AXI_B) ||
                   (state_q == AXI_AR) || (state_q == AXI_R);
  assign tmo_hit = in_axi && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Restart the count on every state change so each AXI phase gets the full budget.
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state_q)) tmo_cnt_q <= '0;
    else if (in_axi)                   tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    case (tx_idx_q)
      3'd0:    tx_byte = status_q;
      3'd1:    tx_byte = rdata_q[7:0];
      3'd2:    tx_byte = rdata_q[15:8];
      3'd3:    tx_byte = rdata_q[23:16];
      3'd4:    tx_byte = rdata_q[31:24];
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt          = state_q;
    rx_ready           = 1'b0;
    tx_valid           = 1'b0;
    tx_data            = 8'h00;
    busy               = (state_q != IDLE);
    m_axi_lite.awvalid = 1'b0;
    m_axi_lite.wvalid  = 1'b0;
    m_axi_lite.bready  = 1'b0;
    m_axi_lite.arvalid = 1'b0;
    m_axi_lite.rready  = 1'b0;
    case (state_q)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid)
          state_nxt = (rx_data == OP_READ || rx_data == OP_WRITE) ? RX_ADDR : TX_RESP;
      end
      RX_ADDR: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_cnt_q == 2'd3) state_nxt = is_wr_q ? RX_DATA : AXI_AR;
      end
      RX_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_cnt_q == 2'd3) state_nxt = AXI_WR;
      end
      AXI_WR: begin
        m_axi_lite.awvalid = !aw_done_q && !tmo_hit;
        m_axi_lite.wvalid  = !w_done_q && !tmo_hit;
        if (tmo_hit)
          state_nxt = TX_RESP;
        else if ((aw_done_q || m_axi_lite.awready) && (w_done_q || m_axi_lite.wready))
          state_nxt = AXI_B;
      end
      AXI_B: begin
        m_axi_lite.bready = !tmo_hit;
        if (tmo_hit || m_axi_lite.bvalid) state_nxt = TX_RESP;
      end
      AXI_AR: begin
        m_axi_lite.arvalid = !tmo_hit;
        if (tmo_hit)                 state_nxt = TX_RESP;
        else if (m_axi_lite.arready) state_nxt = AXI_R;
      end
      AXI_R: begin
        m_axi_lite.rready = !tmo_hit;
        if (tmo_hit || m_axi_lite.rvalid) state_nxt = TX_RESP;
      end
      TX_RESP: begin
        tx_valid = 1'b1;
        tx_data  = tx_byte;
        if (tx_ready && tx_idx_q == tx_last_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      is_wr_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      status_q   <= 8'h00;
      tx_idx_q   <= 3'd0;
      tx_last_q  <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          byte_cnt_q <= 2'd0;
          tx_idx_q   <= 3'd0;
          aw_done_q  <= 1'b0;
          w_done_q   <= 1'b0;
          if (rx_fire) begin
            is_wr_q <= (rx_data == OP_WRITE);
            if (rx_data != OP_READ && rx_data != OP_WRITE) begin
              status_q  <= ST_BAD_OP;
              tx_last_q <= 3'd0;
            end
          end
        end
        RX_ADDR: if (rx_fire) begin
          addr_q     <= {rx_data, addr_q[AXI_ADDR_WIDTH-1:8]};
          byte_cnt_q <= byte_cnt_q + 2'd1;
        end
        RX_DATA: if (rx_fire) begin
          wdata_q    <= {rx_data, wdata_q[AXI_DATA_WIDTH-1:8]};
          byte_cnt_q <= byte_cnt_q + 2'd1;
        end
        AXI_WR: begin
          aw_done_q <= aw_done_q || (m_axi_lite.awvalid && m_axi_lite.awready);
          w_done_q  <= w_done_q || (m_axi_lite.wvalid && m_axi_lite.wready);
          if (tmo_hit) begin
            status_q  <= ST_TIMEOUT;
            tx_last_q <= 3'd0;
          end
        end
        AXI_B: begin
          if (tmo_hit) begin
            status_q  <= ST_TIMEOUT;
            tx_last_q <= 3'd0;
          end else if (m_axi_lite.bvalid) begin
            status_q  <= {6'b0, m_axi_lite.bresp};
            tx_last_q <= 3'd0;
          end
        end
        AXI_AR, AXI_R: begin
          // A timed-out read still returns a full 5-byte response with zero data.
          if (tmo_hit) begin
            status_q  <= ST_TIMEOUT;
            rdata_q   <= '0;
            tx_last_q <= 3'd4;
          end else if (state_q == AXI_R && m_axi_lite.rvalid) begin
            status_q  <= {6'b0, m_axi_lite.rresp};
            rdata_q   <= m_axi_lite.rdata;
            tx_last_q <= 3'd4;
          end
        end
        TX_RESP: if (tx_ready) tx_idx_q <= tx_idx_q + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_to_axi_lite_master.sv
// Randomized scoreboard bench for byte_to_axi_lite_master with a behavioural AXI-Lite slave and host.
module tb_byte_to_axi_lite_master;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  byte_to_axi_lite_master #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .m_axi_lite(axi),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  exp_tx[$];
  logic [63:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];
  int wr_issued = 0;
  int b_seen    = 0;

  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit ar_stuck = 1'b0;
  int tx_mode  = 0;
  bit rx_gaps  = 1'b0;

  // Slave response code is a fixed function of the word address.
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return a[3:2];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (rx_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_mis++;
      $display("FAIL rx_accept: byte %02h not accepted within 5000 cycles", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    exp_wr.push_back({a, d});
    exp_tx.push_back({6'b0, resp_of(a)});
    ref_mem[a] = d;
    wr_issued++;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] d;
    d = ref_mem.exists(a) ? ref_mem[a] : ~a;
    exp_rd.push_back(a);
    exp_tx.push_back({6'b0, resp_of(a)});
    for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic do_bad(input logic [7:0] op);
    exp_tx.push_back(8'hFF);
    send_byte(op);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d response bytes outstanding, busy=%0b", exp_tx.size(), busy);
    end
  endtask

  // Host response side: drives tx_ready and checks every accepted byte against the scoreboard.
  initial begin : tx_monitor
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (!rst && tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL tx_unexpected: got %02h, no byte expected", tx_data);
        end else begin
          chk("tx_byte", tx_data, exp_tx.pop_front());
        end
      end
    end
  end

  // AXI-Lite slave with memory; handshakes decided at negedge take effect at the next posedge.
  initial begin : axi_slave
    bit f_aw, f_w, f_b, f_ar, f_r, aw_got, w_got, ar_got, p_awv, p_wv, p_arv;
    logic [31:0] p_awaddr, p_wdata, p_araddr, c_awaddr, c_wdata, c_araddr;
    int aw_c, w_c, b_c, ar_c, r_c;
    {f_aw, f_w, f_b, f_ar, f_r, aw_got, w_got, ar_got, p_awv, p_wv, p_arv} = '0;
    {p_awaddr, p_wdata, p_araddr, c_awaddr, c_wdata, c_araddr} = '0;
    {aw_c, w_c, b_c, ar_c, r_c} = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        {f_aw, f_w, f_b, f_ar, f_r, aw_got, w_got, ar_got, p_awv, p_wv, p_arv} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
      end else begin
        if (f_aw) begin aw_got = 1'b1; aw_c = 0; end
        if (f_w)  begin w_got  = 1'b1; w_c  = 0; end
        if (f_b)  begin axi.bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_c = 0; end
        if (f_ar) begin ar_got = 1'b1; ar_c = 0; end
        if (f_r)  begin axi.rvalid = 1'b0; ar_got = 1'b0; r_c = 0; end
        if (p_awv && !f_aw) begin
          chk("awvalid_hold", axi.awvalid, 1);
          chk("awaddr_stable", axi.awaddr, p_awaddr);
        end
        if (p_wv && !f_w) begin
          chk("wvalid_hold", axi.wvalid, 1);
          chk("wdata_stable", axi.wdata, p_wdata);
        end
        if (p_arv && !f_ar && !ar_stuck) begin
          chk("arvalid_hold", axi.arvalid, 1);
          chk("araddr_stable", axi.araddr, p_araddr);
        end
        axi.awready = 1'b0;
        if (axi.awvalid && !aw_got) begin
          if (aw_c >= aw_dly) axi.awready = 1'b1; else aw_c++;
        end
        axi.wready = 1'b0;
        if (axi.wvalid && !w_got) begin
          if (w_c >= w_dly) axi.wready = 1'b1; else w_c++;
        end
        axi.arready = 1'b0;
        if (axi.arvalid && !ar_got && !ar_stuck) begin
          if (ar_c >= ar_dly) axi.arready = 1'b1; else ar_c++;
        end
        if (aw_got && w_got && !axi.bvalid) begin
          if (b_c >= b_dly) begin
            smem[c_awaddr] = c_wdata;
            axi.bvalid = 1'b1;
            axi.bresp  = resp_of(c_awaddr);
          end else b_c++;
        end
        if (ar_got && !axi.rvalid) begin
          if (r_c >= r_dly) begin
            axi.rvalid = 1'b1;
            axi.rdata  = smem.exists(c_araddr) ? smem[c_araddr] : ~c_araddr;
            axi.rresp  = resp_of(c_araddr);
          end else r_c++;
        end
        f_aw = axi.awvalid && axi.awready;
        f_w  = axi.wvalid && axi.wready;
        f_b  = axi.bvalid && axi.bready;
        f_ar = axi.arvalid && axi.arready;
        f_r  = axi.rvalid && axi.rready;
        if (f_aw) begin
          c_awaddr = axi.awaddr;
          chk("awprot", axi.awprot, 0);
          if (exp_wr.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL aw_unexpected: awaddr %08h with no write outstanding", axi.awaddr);
          end else chk("awaddr", axi.awaddr, exp_wr[0][63:32]);
        end
        if (f_w) begin
          c_wdata = axi.wdata;
          chk("wstrb", axi.wstrb, 4'hF);
          if (exp_wr.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL w_unexpected: wdata %08h with no write outstanding", axi.wdata);
          end else chk("wdata", axi.wdata, exp_wr[0][31:0]);
        end
        if (f_b) begin
          b_seen++;
          if (exp_wr.size() != 0) void'(exp_wr.pop_front());
        end
        if (f_ar) begin
          c_araddr = axi.araddr;
          chk("arprot", axi.arprot, 0);
          if (exp_rd.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL ar_unexpected: araddr %08h with no read outstanding", axi.araddr);
          end else chk("araddr", axi.araddr, exp_rd.pop_front());
        end
        p_awv = axi.awvalid && !f_aw; p_awaddr = axi.awaddr;
        p_wv  = axi.wvalid && !f_w;   p_wdata  = axi.wdata;
        p_arv = axi.arvalid && !f_ar; p_araddr = axi.araddr;
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [7:0]  op;
    int k;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_rready", axi.rready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_rst", rx_ready, 1);

    do_write(32'h8000_0010, 32'hDEAD_BEEF);
    drain();
    r_dly = 1;
    do_read(32'h8000_0010);
    drain();
    r_dly = 0;

    aw_dly = 5; w_dly = 0;
    do_write(32'h8000_0024, 32'h1234_5678);
    drain();
    chk("b_count_aw_stall", b_seen, wr_issued);
    aw_dly = 0;

    do_bad(8'h7A);
    do_read(32'h8000_0024);
    drain();

    tx_mode = 1; rx_gaps = 1'b1;
    do_read(32'h8000_0010);
    do_read(32'h4000_0008);
    drain();
    tx_mode = 0; rx_gaps = 1'b0;

    for (int n = 0; n < 60; n++) begin
      aw_dly = $urandom_range(0, 4); w_dly  = $urandom_range(0, 4);
      b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 4);
      r_dly  = $urandom_range(0, 3);
      tx_mode = $urandom_range(0, 2);
      rx_gaps = 1'($urandom_range(0, 1));
      a = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
      k = $urandom_range(0, 9);
      if (k < 4) do_write(a, $urandom);
      else if (k < 9) do_read(a);
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h01 || op == 8'h02) op = 8'hA5;
        do_bad(op);
      end
    end
    drain();
    tx_mode = 0; rx_gaps = 1'b0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

    send_byte(8'h02);
    send_byte(8'h44);
    send_byte(8'h33);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_awvalid", axi.awvalid, 0);
    chk("midrst_wvalid", axi.wvalid, 0);
    chk("midrst_arvalid", axi.arvalid, 0);
    chk("midrst_tx_valid", tx_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    do_read(32'h4000_0004);
    drain();

`ifdef AXI_TIMEOUT_EN
    ar_stuck = 1'b1;
    exp_tx.push_back(8'h80);
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'h00);
    send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
    drain();
    ar_stuck = 1'b0;
    do_read(32'h8000_0010);
    drain();
`endif

    chk("b_count_total", b_seen, wr_issued);
    chk("writes_outstanding", exp_wr.size(), 0);
    chk("reads_outstanding", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
